// File: rtl/stereo_matrix_decoder.sv
// Inverse stereo matrix: undoes the sum/difference gains with two lockstep
// restoring dividers, then rebuilds saturated left/right samples.
module stereo_matrix_decoder #(
  parameter int DW = 18,
  parameter int KW = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic signed [DW-1:0] LpR_in,
  input  logic signed [DW-1:0] LmR_in,
  input  logic        [KW-1:0] Ks,
  input  logic        [KW-1:0] Kd,
  input  logic                 valid_in,
  output logic                 busy,
  output logic signed [DW-1:0] LEFT_out,
  output logic signed [DW-1:0] RIGHT_out,
  output logic                 out_valid,
  output logic                 overrun
);

  localparam int NW = DW + 4;
  localparam int MW = DW + 3;
  localparam int RW = KW + 1;
  localparam int SW = DW + 5;
  localparam int CW = $clog2(MW + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_SIGN, S_COMB} state_t;

  state_t                r_state;
  logic signed [DW-1:0]  r_lpr, r_lmr;
  logic        [KW-1:0]  r_ks, r_kd;
  logic                  r_neg_s, r_neg_d;
  logic        [MW-1:0]  r_q_s, r_q_d;
  logic        [RW-1:0]  r_rem_s, r_rem_d;
  logic        [CW-1:0]  r_cnt;
  logic signed [NW-1:0]  r_s, r_d;

  logic signed [NW-1:0]  w_num_s, w_num_d;
  logic        [MW-1:0]  w_mag_s, w_mag_d;
  logic        [MW-1:0]  w_q_s_n, w_q_d_n;
  logic        [RW-1:0]  w_rem_s_n, w_rem_d_n;
  logic signed [SW-1:0]  w_sum, w_diff;

  // One restoring step: shift the next numerator bit into the remainder and
  // subtract the divisor when it fits; the quotient bit enters from the right.
  function automatic logic [RW+MW-1:0] div_step(input logic [MW-1:0] q,
                                                 input logic [RW-1:0] rem,
                                                 input logic [KW-1:0] k);
    logic [RW-1:0] sh;
    logic [MW-1:0] nq;
    sh = {rem[RW-2:0], q[MW-1]};
    nq = {q[MW-2:0], 1'b0};
    if (sh >= {1'b0, k}) begin
      sh    = sh - {1'b0, k};
      nq[0] = 1'b1;
    end
    return {sh, nq};
  endfunction

  function automatic logic signed [DW-1:0] sat(input logic signed [SW-1:0] v);
    if (v[SW-1:DW-1] == '0 || v[SW-1:DW-1] == '1)
      return v[DW-1:0];
    else if (v[SW-1])
      return {1'b1, {(DW-1){1'b0}}};
    else
      return {1'b0, {(DW-1){1'b1}}};
  endfunction

  assign w_num_s = {r_lpr[DW-1], r_lpr, 3'b000};
  assign w_num_d = {r_lmr[DW-1], r_lmr, 3'b000};
  assign w_mag_s = MW'(r_lpr[DW-1] ? -w_num_s : w_num_s);
  assign w_mag_d = MW'(r_lmr[DW-1] ? -w_num_d : w_num_d);

  assign {w_rem_s_n, w_q_s_n} = div_step(r_q_s, r_rem_s, r_ks);
  assign {w_rem_d_n, w_q_d_n} = div_step(r_q_d, r_rem_d, r_kd);

  assign w_sum  = r_s + r_d;
  assign w_diff = r_s - r_d;

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_lpr     <= '0;
      r_lmr     <= '0;
      r_ks      <= '0;
      r_kd      <= '0;
      r_neg_s   <= 1'b0;
      r_neg_d   <= 1'b0;
      r_q_s     <= '0;
      r_q_d     <= '0;
      r_rem_s   <= '0;
      r_rem_d   <= '0;
      r_cnt     <= '0;
      r_s       <= '0;
      r_d       <= '0;
      LEFT_out  <= '0;
      RIGHT_out <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= valid_in && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (valid_in) begin
            r_lpr   <= LpR_in;
            r_lmr   <= LmR_in;
            r_ks    <= Ks;
            r_kd    <= Kd;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          // A zero gain code leaves a zero quotient so that term drops out.
          r_neg_s <= r_lpr[DW-1];
          r_neg_d <= r_lmr[DW-1];
          r_q_s   <= (r_ks == '0) ? '0 : w_mag_s;
          r_q_d   <= (r_kd == '0) ? '0 : w_mag_d;
          r_rem_s <= '0;
          r_rem_d <= '0;
          r_cnt   <= CW'(MW);
          r_state <= S_DIV;
        end
        S_DIV: begin
          if (r_ks != '0) begin
            r_q_s   <= w_q_s_n;
            r_rem_s <= w_rem_s_n;
          end
          if (r_kd != '0) begin
            r_q_d   <= w_q_d_n;
            r_rem_d <= w_rem_d_n;
          end
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1))
            r_state <= S_SIGN;
        end
        S_SIGN: begin
          r_s     <= r_neg_s ? -$signed({1'b0, r_q_s}) : $signed({1'b0, r_q_s});
          r_d     <= r_neg_d ? -$signed({1'b0, r_q_d}) : $signed({1'b0, r_q_d});
          r_state <= S_COMB;
        end
        S_COMB: begin
          LEFT_out  <= sat(w_sum >>> 1);
          RIGHT_out <= sat(w_diff >>> 1);
          out_valid <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stereo_matrix_decoder.sv
// Scoreboard bench for stereo_matrix_decoder: stimulus pushes expected pairs
// and arrival cycles, a negedge monitor pops and compares on out_valid.
module tb_stereo_matrix_decoder;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic signed [17:0] LpR_in = '0;
  logic signed [17:0] LmR_in = '0;
  logic        [3:0]  Ks = '0;
  logic        [3:0]  Kd = '0;
  logic               valid_in = 1'b0;
  logic               busy;
  logic signed [17:0] LEFT_out;
  logic signed [17:0] RIGHT_out;
  logic               out_valid;
  logic               overrun;

  stereo_matrix_decoder #(.DW(18), .KW(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .LpR_in    (LpR_in),
    .LmR_in    (LmR_in),
    .Ks        (Ks),
    .Kd        (Kd),
    .valid_in  (valid_in),
    .busy      (busy),
    .LEFT_out  (LEFT_out),
    .RIGHT_out (RIGHT_out),
    .out_valid (out_valid),
    .overrun   (overrun)
  );

  always #5 clock = ~clock;

  typedef struct {
    longint l;
    longint r;
    int     cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   n_ovr = 0;
  logic prev_ov = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected pair, on time.
  always @(negedge clock) begin
    exp_t e;
    if (reset && out_valid) begin
      chk("out_valid_not_consecutive", prev_ov, 0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got L=%0d R=%0d, expected none", LEFT_out, RIGHT_out);
      end else begin
        e = sb.pop_front();
        chk("LEFT_out", LEFT_out, e.l);
        chk("RIGHT_out", RIGHT_out, e.r);
        chk("latency_cycle", cyc, e.cyc);
      end
    end
    prev_ov = out_valid;
    if (overrun) n_ovr++;
  end

  // Called at a negedge; drives one valid_in pulse and returns at the next negedge.
  task automatic send(input int l, input int m, input int ks, input int kd,
                      input int el, input int er, input bit push);
    exp_t e;
    LpR_in   = 18'(l);
    LmR_in   = 18'(m);
    Ks       = 4'(ks);
    Kd       = 4'(kd);
    valid_in = 1'b1;
    if (push) begin
      e.l   = el;
      e.r   = er;
      e.cyc = cyc + 1 + 24;
      sb.push_back(e);
    end
    @(negedge clock);
    valid_in = 1'b0;
    LpR_in   = 18'(12345);
    LmR_in   = -18'(777);
    Ks       = 4'(15);
    Kd       = 4'(15);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_done_timeout: got %0d pending, expected 0", sb.size());
    end
    @(negedge clock);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    exp_t dropped;

    // Reset state
    repeat (3) @(negedge clock);
    chk("reset_LEFT", LEFT_out, 0);
    chk("reset_RIGHT", RIGHT_out, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_busy", busy, 0);
    reset = 1'b1;

    // Unity gain, busy window length
    @(negedge clock);
    send(1000, 200, 8, 8, 600, 400, 1);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("busy_cycles", n, 24);
    wait_done();

    // Truncation toward zero, floor on odd negative sum, saturation, zero gain
    send(-100, 0, 3, 8, -133, -133, 1);
    wait_done();
    send(-3, 0, 8, 8, -2, -2, 1);
    wait_done();
    send(131071, 131071, 1, 1, 131071, 0, 1);
    wait_done();
    send(-131072, 131071, 1, 1, -4, -131072, 1);
    wait_done();
    send(500, 12345, 4, 0, 500, 500, 1);
    wait_done();
    chk("no_overrun_so_far", n_ovr, 0);

    // Overrun: pair B five cycles after A is dropped
    send(300, 100, 8, 8, 200, 100, 1);
    repeat (3) @(negedge clock);
    send(-5000, 4000, 8, 8, -500, -4500, 0);
    chk("overrun_pulse", overrun, 1);
    @(negedge clock);
    chk("overrun_one_cycle", overrun, 0);
    n = 0;
    while (!out_valid && n < 60) begin
      @(negedge clock);
      n++;
    end
    chk("A_out_valid_seen", out_valid, 1);
    // Pair C presented in A's out_valid cycle
    send(-7, 33, 2, 5, 12, -40, 1);
    chk("C_accepted_busy", busy, 1);
    wait_done();
    chk("overrun_total", n_ovr, 1);

    // Reset mid-operation aborts the pair; next pair follows immediately
    send(2000, 2000, 8, 8, 2000, 0, 1);
    repeat (9) @(negedge clock);
    dropped = sb.pop_back();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    chk("abort_LEFT", LEFT_out, 0);
    chk("abort_RIGHT", RIGHT_out, 0);
    chk("abort_busy", busy, 0);
    send(1234, -999, 7, 3, -627, 2037, 1);
    wait_done();
    chk("dropped_pair_L_unused", dropped.l, 2000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
